// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Holds the receive state encoding
//                and the half-bit-period helper that the transmit and
//                receive ends both use.
//  Contents    : state_t       - 3-bit FSM state encoding
//                half_period() - integer half of the bit-period divider
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // A bit period is clk_div+1 clocks; the mid-bit offset is clk_div/2.
   function automatic int half_period(input int clk_div);
      return clk_div / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial-line and received-word bundle for uart_rx.
//  Ports       : i_rx        - serial line into the receiver (idles high)
//                o_data      - last good word
//                o_valid     - one-cycle good-frame strobe
//                o_frame_err - one-cycle framing-error strobe
//                o_active    - receiver busy with a frame
//  Modports    : slave  - the receiver
//                master - the line driver / word consumer
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
   parameter int p_WORD_LEN = 8
);
   logic                  i_rx;
   logic [p_WORD_LEN-1:0] o_data;
   logic                  o_valid;
   logic                  o_frame_err;
   logic                  o_active;

   modport slave  (input  i_rx, output o_data, output o_valid, output o_frame_err, output o_active);
   modport master (output i_rx, input  o_data, input  o_valid, input  o_frame_err, input  o_active);
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//  Ports       : i_clk   - destination clock
//                i_rst_n - asynchronous active-low reset
//                i_d     - asynchronous input
//                o_q     - synchronized output
//  Parameters  : p_RESET_VAL - value both flops take in reset
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter bit p_RESET_VAL = 1'b0
) (
   input  wire logic i_clk,
   input  wire logic i_rst_n,
   input  wire logic i_d,
   output logic      o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= p_RESET_VAL;
         r_sync <= p_RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. 1 start bit, p_WORD_LEN data bits LSB first,
//                1 stop bit. Emits a one-cycle o_valid per good frame and a
//                one-cycle o_frame_err when the stop bit is sampled low.
//  Ports       : i_clk   - clock, rising edge
//                i_rst_n - asynchronous active-low reset
//                bus     - uart_rx_if.slave (i_rx, o_data, o_valid,
//                          o_frame_err, o_active)
//  Parameters  : p_CLK_DIV  - bit period is p_CLK_DIV+1 clocks (>= 3)
//                p_WORD_LEN - data bits per frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int p_CLK_DIV  = 104,
   parameter int p_WORD_LEN = 8
) (
   input wire logic i_clk,
   input wire logic i_rst_n,
   uart_rx_if.slave bus
);

   localparam int CW = $clog2(p_CLK_DIV + 1);
   localparam int BW = $clog2(p_WORD_LEN + 1);

   localparam logic [CW-1:0] c_HALF     = CW'(half_period(p_CLK_DIV));
   localparam logic [CW-1:0] c_DIV      = CW'(p_CLK_DIV);
   localparam logic [CW-1:0] c_CLK_ONE  = CW'(1);
   localparam logic [BW-1:0] c_LAST_BIT = BW'(p_WORD_LEN - 1);
   localparam logic [BW-1:0] c_BIT_ONE  = BW'(1);

   logic                  w_rx_s;
   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_clk_cnt;
   logic [BW-1:0]         r_bit_cnt;
   logic [p_WORD_LEN-1:0] r_shift;
   logic [p_WORD_LEN-1:0] r_data;
   logic                  r_valid;
   logic                  r_frame_err;
   logic                  r_active;

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   sync_2ff #(
      .p_RESET_VAL (1'b1)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (bus.i_rx),
      .o_q     (w_rx_s)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (!w_rx_s) w_state_next = ST_START;
         // Start bit must still be low at mid-bit, otherwise it was a glitch.
         ST_START: if (r_clk_cnt == c_HALF) w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:  if (r_clk_cnt == c_DIV && r_bit_cnt == c_LAST_BIT) w_state_next = ST_STOP;
         ST_STOP:  if (r_clk_cnt == c_DIV) w_state_next = w_rx_s ? ST_IDLE : ST_BREAK;
         // Hold off until the line returns high so a stuck-low line is not
         // mistaken for a fresh start bit.
         ST_BREAK: if (w_rx_s) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Counters, shift register and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_clk_cnt <= '0;
               r_bit_cnt <= '0;
               r_active  <= !w_rx_s;
            end
            ST_START: begin
               if (r_clk_cnt == c_HALF) begin
                  r_clk_cnt <= '0;
                  if (w_rx_s) r_active <= 1'b0;
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CLK_ONE;
               end
            end
            ST_DATA: begin
               if (r_clk_cnt == c_DIV) begin
                  r_clk_cnt <= '0;
                  // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                  r_shift   <= {w_rx_s, r_shift[p_WORD_LEN-1:1]};
                  r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? '0 : r_bit_cnt + c_BIT_ONE;
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CLK_ONE;
               end
            end
            ST_STOP: begin
               if (r_clk_cnt == c_DIV) begin
                  r_clk_cnt <= '0;
                  if (w_rx_s) begin
                     r_data   <= r_shift;
                     r_valid  <= 1'b1;
                     r_active <= 1'b0;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CLK_ONE;
               end
            end
            ST_BREAK: begin
               if (w_rx_s) r_active <= 1'b0;
            end
            default: begin
               r_clk_cnt <= '0;
               r_bit_cnt <= '0;
               r_active  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_data      = r_data;
   assign bus.o_valid     = r_valid;
   assign bus.o_frame_err = r_frame_err;
   assign bus.o_active    = r_active;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART link. The block recovers framed serial data from the asynchronous `i_rx` line: one start bit (low), `p_WORD_LEN` data bits sent LSB first, and one stop bit (high). It presents each received word on a one-cycle `o_valid` strobe and reports framing errors. It sits directly downstream of the transmitter on the serial line and uses the same bit-period convention.

## Interface
- `p_CLK_DIV`, default 104: one bit period is `p_CLK_DIV+1` clocks. Must be ≥ 3.
- `p_WORD_LEN`, default 8: number of data bits per frame.
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_rx`, in, 1: serial line; asynchronous to `i_clk`; idles high.
- `o_data`, out, `p_WORD_LEN`: last good word; valid while `o_valid`=1 and held afterwards.
- `o_valid`, out, 1: one-cycle pulse, good frame received.
- `o_frame_err`, out, 1: one-cycle pulse, stop bit sampled low.
- `o_active`, out, 1: high from start-bit detection until the block returns to IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer; both flops reset to 1. Call the synchronized signal `rx_s`.
- Counters:
  - `clk_cnt` has width `$clog2(p_CLK_DIV+1)`.
  - `bit_cnt` has width `$clog2(p_WORD_LEN+1)`.
  - Half period `H = p_CLK_DIV/2` (integer division).
- State machine. The state register resets to IDLE.
  - **IDLE:** `clk_cnt`=0, `bit_cnt`=0, `o_active`=0. If `rx_s`=0, go to START and set `o_active`=1.
  - **START:** increment `clk_cnt` while `clk_cnt` < H. When `clk_cnt`==H:
    - If `rx_s`=0, go to DATA with `clk_cnt`=0.
    - Otherwise the low was a glitch: go to IDLE, with no pulse output.
  - **DATA:** increment `clk_cnt` while `clk_cnt` < `p_CLK_DIV`. When `clk_cnt`==`p_CLK_DIV`:
    - Shift `rx_s` into the shift register MSB-side, so the first bit received ends up at bit 0.
    - Set `clk_cnt`=0 and increment `bit_cnt`.
    - On the sample of bit `p_WORD_LEN-1`, go to STOP with `bit_cnt`=0.
  - **STOP:** when `clk_cnt`==`p_CLK_DIV`, sample `rx_s`:
    - If 1: load `o_data` from the shift register, pulse `o_valid`, go to IDLE.
    - If 0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
  - **BREAK:** wait while `rx_s`=0. On `rx_s`=1, go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Pulses are registered: high for exactly one cycle, following the edge that sampled the stop bit.
- The shift register is internal; only `o_data` is visible.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_active`=0.
  - Synchronizer flops = 1.
  - State = IDLE, counters = 0.
- Reset mid-frame clears all of the above immediately. No pulse is emitted for the aborted frame.
- Reference edge: let T0 be the clock edge at which the first synchronizer flop captures `i_rx`=0.
  - The START entry edge is T0+2.
  - Data bit k (0-based) is sampled at edge T0+H+3+(k+1)(`p_CLK_DIV`+1).
  - The stop bit is sampled at edge T0+H+3+(`p_WORD_LEN`+1)(`p_CLK_DIV`+1).
  - `o_valid` or `o_frame_err` is high during the cycle following that edge.
- `o_active` rises at edge T0+2 and falls at the edge that enters IDLE.
- Back-to-back frames: IDLE is entered on the stop-sample edge, so a start bit whose low level is already in `rx_s` is detected on the next edge. No dead cycle is required beyond the stop bit.
- A glitch shorter than H+1 cycles at `rx_s` returns the block to IDLE at edge T0+H+3.
- `o_valid` and `o_frame_err` are never high in the same cycle.

## Structure
- Shared package `uart_pkg` holds:
  - The state encodings: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits).
  - A constant function for the half period, usable by both the transmit and receive ends.
- One sub-module: `sync_2ff`.
  - 2-flop synchronizer with async active-low reset.
  - Reset value is a parameter, set to 1 here.
- Everything else lives in a single FSM process in `uart_rx`.

## Test plan
All scenarios use `p_CLK_DIV`=15 (16 clocks/bit), `p_WORD_LEN`=8, H=7.
- **Reset:** assert `i_rst_n`=0 with `i_rx` toggling → all outputs 0. Release with `i_rx`=1 → `o_active` stays 0.
- **Good frame:** send 0xA5 → exactly one `o_valid` pulse with `o_data`=0xA5, `o_frame_err`=0. The pulse occurs in the cycle after edge T0+10+9·16.
- **Start glitch:** hold `i_rx` low for 4 clocks → no pulse; `o_active` drops back to 0 within 12 clocks.
- **Framing error:** send 0x3C with stop bit 0, then hold the line low for 40 more clocks → one `o_frame_err` pulse, no `o_valid`, `o_data` keeps its prior value. After the line returns high, 0x5A is received correctly.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `o_valid` pulses, 160 clocks apart, data 0x00 then 0xFF.
- **Reset mid-frame:** assert reset during data bit 3 → outputs clear at once and no pulse appears. After release, 0x81 is received correctly.
